// File: rtl/ct_rst_req_ctrl.sv
// ct_rst_req_ctrl: collects debug / watchdog / software reset requests and
// runs a request/acknowledge handshake with the SoC reset controller.
// The request is held for a programmable minimum length and then until the
// acknowledge is seen. The FSM then waits for the acknowledge to drop. A
// timeout on either wait aborts the handshake and sets a sticky error flag.
module ct_rst_req_ctrl (
    input  logic       forever_coreclk,
    input  logic       forever_cpurst,
    input  logic       had_rst_req,
    input  logic       wdt_rst_req,
    input  logic       sw_rst_req,
    input  logic [3:0] rst_req_len,
    input  logic       pad_rst_ack,
    output logic       core_rst_req,
    output logic [2:0] rst_cause,
    output logic       rst_busy,
    output logic       rst_ack_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t     state;
    logic       ack_meta;
    logic       ack_sync;
    logic       had_d;
    logic [2:0] pending;
    logic [2:0] new_req;
    logic [2:0] req_all;
    logic [3:0] len_cnt;
    logic [7:0] to_cnt;
    logic       start;

    // Cause bit order is {sw, wdt, had}; the debug request is level, so only its rising edge counts
    assign new_req  = {sw_rst_req, wdt_rst_req, had_rst_req & ~had_d};
    assign req_all  = pending | new_req;
    // A stale acknowledge still high from a previous handshake blocks a new start
    assign start    = (state == S_IDLE) && (req_all != 3'b000) && !ack_sync;
    assign rst_busy = (state != S_IDLE);

    // Two-flop synchroniser for the asynchronous acknowledge
    always_ff @(posedge forever_coreclk or posedge forever_cpurst) begin
        if (forever_cpurst) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= pad_rst_ack;
            ack_sync <= ack_meta;
        end
    end

    // Delay register for debug-request edge detection
    always_ff @(posedge forever_coreclk or posedge forever_cpurst) begin
        if (forever_cpurst) had_d <= 1'b0;
        else                had_d <= had_rst_req;
    end

    // Pending requests accumulate until a sequence starts, so none is lost while busy or blocked
    always_ff @(posedge forever_coreclk or posedge forever_cpurst) begin
        if (forever_cpurst) pending <= 3'b000;
        else if (start)     pending <= 3'b000;
        else                pending <= req_all;
    end

    // Handshake FSM with registered request, cause and timeout outputs
    always_ff @(posedge forever_coreclk or posedge forever_cpurst) begin
        if (forever_cpurst) begin
            state           <= S_IDLE;
            len_cnt         <= 4'd0;
            to_cnt          <= 8'd0;
            core_rst_req    <= 1'b0;
            rst_cause       <= 3'b000;
            rst_ack_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    core_rst_req <= 1'b0;
                    if (start) begin
                        state        <= S_ASSERT;
                        rst_cause    <= req_all;
                        len_cnt      <= rst_req_len;
                        core_rst_req <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    core_rst_req <= 1'b1;
                    if (len_cnt == 4'd0) begin
                        state  <= S_WAIT;
                        to_cnt <= 8'd0;
                    end else begin
                        len_cnt <= len_cnt - 4'd1;
                    end
                end
                S_WAIT: begin
                    if (ack_sync) begin
                        state        <= S_RELEASE;
                        to_cnt       <= 8'd0;
                        core_rst_req <= 1'b0;
                    end else if (to_cnt == 8'd255) begin
                        state           <= S_IDLE;
                        core_rst_req    <= 1'b0;
                        rst_ack_timeout <= 1'b1;
                    end else begin
                        to_cnt       <= to_cnt + 8'd1;
                        core_rst_req <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    core_rst_req <= 1'b0;
                    if (!ack_sync) begin
                        state <= S_IDLE;
                    end else if (to_cnt == 8'd255) begin
                        state           <= S_IDLE;
                        rst_ack_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    core_rst_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_rst_req_ctrl.sv
// Scoreboard bench: each scenario computes its expected request windows from
// the handshake timing rules and queues them; a monitor compares every
// request rise/fall and busy drop the DUT produces.
module tb_ct_rst_req_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       had = 1'b0, wdt = 1'b0, sw = 1'b0, pad = 1'b0;
    logic [3:0] len = 4'd0;
    logic       core_rst_req, rst_busy, rst_ack_timeout;
    logic [2:0] rst_cause;

    ct_rst_req_ctrl dut (
        .forever_coreclk(clk),
        .forever_cpurst (rst),
        .had_rst_req    (had),
        .wdt_rst_req    (wdt),
        .sw_rst_req     (sw),
        .rst_req_len    (len),
        .pad_rst_ack    (pad),
        .core_rst_req   (core_rst_req),
        .rst_cause      (rst_cause),
        .rst_busy       (rst_busy),
        .rst_ack_timeout(rst_ack_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         rise;
        int         fall;
        int         idle;
        logic [2:0] cause;
        logic       tout;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic sticky = 1'b0;

    task automatic chk(input string name, input logic ok, input int act, input int expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic push(input int rise, input int fall, input int idle, input logic [2:0] c, input logic t);
        exp_t e;
        e.rise = rise; e.fall = fall; e.idle = idle; e.cause = c; e.tout = t;
        q.push_back(e);
    endtask

    // Plays a timeline: request mask at n (had held 3 cycles), extra sw pulse at s,
    // pad acknowledge high in [a1,f1) and [a2,f2). Called just after a posedge.
    task automatic drive(input int n, input logic [2:0] m, input int s,
                         input int a1, input int f1, input int a2, input int f2, input int endc);
        while (cyc < endc) begin
            wdt = (cyc == n) && m[1];
            sw  = ((cyc == n) && m[2]) || (cyc == s);
            had = m[0] && (cyc >= n) && (cyc < n + 3);
            pad = ((cyc >= a1) && (cyc < f1)) || ((cyc >= a2) && (cyc < f2));
            @(posedge clk); #1;
        end
        wdt = 1'b0; sw = 1'b0; had = 1'b0; pad = 1'b0;
    endtask

    // Request at n lifts core_rst_req at n+1; it stays up len+1 ASSERT cycles plus
    // at least one WAIT cycle, and drops 3 cycles after the pad ack rises.
    task automatic seq_normal(input logic [2:0] m, input int l, input int adly, input int fdly);
        int n, rise, a, fall, f;
        len  = l[3:0];
        n    = cyc + 2;
        rise = n + 1;
        a    = n + adly;
        fall = mx(a + 3, rise + 2 + l);
        f    = fall + fdly;
        push(rise, fall, f + 3, m, sticky);
        drive(n, m, -1, a, f, -1, -1, f + 6);
    endtask

    // No acknowledge: 256 WAIT cycles, then abort with the sticky flag.
    task automatic seq_timeout(input logic [2:0] m, input int l);
        int n, rise, fall;
        len    = l[3:0];
        n      = cyc + 2;
        rise   = n + 1;
        fall   = rise + l + 1 + 256;
        sticky = 1'b1;
        push(rise, fall, fall, m, 1'b1);
        drive(n, m, -1, -1, -1, -1, -1, fall + 3);
    endtask

    // Ack already high when the request comes: held until 3 cycles after the pad drops.
    task automatic seq_stale(input logic [2:0] m, input int l, input int fd, input int ad, input int fd2);
        int a0, n, f0, rise, a2, fall, f2;
        len  = l[3:0];
        a0   = cyc + 2;
        n    = a0 + 3;
        f0   = n + fd;
        rise = f0 + 3;
        a2   = rise + ad;
        fall = mx(a2 + 3, rise + 2 + l);
        f2   = fall + fd2;
        push(rise, fall, f2 + 3, m, sticky);
        drive(n, m, -1, a0, f0, a2, f2, f2 + 6);
    endtask

    // sw pulse while waiting for ack: a second sequence starts right after IDLE.
    task automatic seq_wait_sw(input logic [2:0] m, input int l);
        int n, rise, a, fall, f, s, rise2, a2, fall2, f2;
        len   = l[3:0];
        n     = cyc + 2;
        rise  = n + 1;
        a     = n + l + 12;
        fall  = mx(a + 3, rise + 2 + l);
        f     = fall + 2;
        s     = n + l + 4;
        rise2 = f + 4;
        a2    = rise2 + 3;
        fall2 = mx(a2 + 3, rise2 + 2 + l);
        f2    = fall2 + 1;
        push(rise, fall, f + 3, m, sticky);
        push(rise2, fall2, f2 + 3, 3'b100, sticky);
        drive(n, m, s, a, f, a2, f2, f2 + 6);
    endtask

    // Monitor: compares each observed request window against the queue head
    initial begin
        logic pc, pb, act;
        exp_t cur;
        pc = 1'b0; pb = 1'b0; act = 1'b0;
        cur.rise = 0; cur.fall = 0; cur.idle = 0; cur.cause = 3'b000; cur.tout = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0; pc = 1'b0; pb = 1'b0;
            end else begin
                if (core_rst_req && !pc) begin
                    if (q.size() == 0) begin
                        chk("unexpected_req", 1'b0, cyc, -1);
                    end else begin
                        cur = q.pop_front();
                        act = 1'b1;
                        chk("rise_cycle", cyc == cur.rise, cyc, cur.rise);
                        chk("cause", rst_cause == cur.cause, int'(rst_cause), int'(cur.cause));
                        chk("busy_at_rise", rst_busy == 1'b1, int'(rst_busy), 1);
                    end
                end
                if (!core_rst_req && pc && act) begin
                    chk("fall_cycle", cyc == cur.fall, cyc, cur.fall);
                    chk("timeout_flag", rst_ack_timeout == cur.tout, int'(rst_ack_timeout), int'(cur.tout));
                end
                if (!rst_busy && pb && act) begin
                    chk("idle_cycle", cyc == cur.idle, cyc, cur.idle);
                    chk("cause_held", rst_cause == cur.cause, int'(rst_cause), int'(cur.cause));
                    act = 1'b0;
                end
                pc = core_rst_req;
                pb = rst_busy;
            end
        end
    end

    initial begin
        int n;
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_core", core_rst_req == 1'b0, int'(core_rst_req), 0);
        chk("rst_busy", rst_busy == 1'b0, int'(rst_busy), 0);
        chk("rst_cause", rst_cause == 3'b000, int'(rst_cause), 0);
        chk("rst_tout", rst_ack_timeout == 1'b0, int'(rst_ack_timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        seq_normal(3'b010, 3, 10, 5);          // watchdog, len 3
        seq_normal(3'b101, 2, 6, 1);           // had edge + sw together
        seq_normal(3'b001, 0, 1, 0);           // minimum length
        seq_normal(3'b100, 15, 2, 3);          // maximum length, early ack
        seq_wait_sw(3'b010, 2);
        seq_stale(3'b010, 1, 3, 4, 2);
        for (int i = 0; i < 8; i++)
            seq_normal(3'($urandom_range(1, 7)), int'($urandom_range(0, 15)),
                       int'($urandom_range(1, 20)), int'($urandom_range(0, 6)));
        seq_timeout(3'b100, 4);
        seq_normal(3'b010, 1, 5, 2);           // flag must stay set
        seq_stale(3'($urandom_range(1, 7)), int'($urandom_range(0, 15)), 2, 3, 1);

        // reset in the middle of ASSERT
        len = 4'd8;
        n   = cyc + 2;
        push(n + 1, 0, 0, 3'b010, sticky);
        drive(n, 3'b010, -1, -1, -1, -1, -1, n + 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_core", core_rst_req == 1'b0, int'(core_rst_req), 0);
        chk("midrst_busy", rst_busy == 1'b0, int'(rst_busy), 0);
        chk("midrst_cause", rst_cause == 3'b000, int'(rst_cause), 0);
        chk("midrst_tout", rst_ack_timeout == 1'b0, int'(rst_ack_timeout), 0);
        sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        seq_normal(3'b001, 2, 4, 1);           // clean start after reset

        repeat (4) begin @(posedge clk); #1; end
        chk("queue_empty", q.size() == 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
